fwd_hazard_unit: RTL

- Parametrised successor to the combinational forwarding unit.
- Tracks destination registers of in-flight instructions in an internal EX/MEM/WB shadow pipeline.
- Generates per-operand ALU forwarding selects with MEM-over-WB priority.
- Detects load-use hazards and drives a counted stall plus EX bubble insertion. Sits beside the ID/EX pipeline registers of the 5-stage core.

---
 rtl/fwd_hazard_unit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall unit with an EX/MEM/WB shadow pipeline.
// Optional event counters are built when FWD_HAZARD_STATS_EN is defined.
module fwd_hazard_unit #(
  parameter int REG_ADDR_W        = 5,
  parameter int NUM_SRC           = 2,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]            id_rs_used,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_reg_write,
  input  logic                          id_is_load,
  input  logic                          flush,
  output logic                          stall_out,
`ifdef FWD_HAZARD_STATS_EN
  output logic [31:0]                   stat_fwd_cnt,
  output logic [31:0]                   stat_stall_cnt,
`endif
  output logic [2*NUM_SRC-1:0]          fwd_sel
);

  if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 7) begin : g_bad_cfg
    $error("LOAD_STALL_CYCLES must be in 1..7");
  end

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

  typedef struct packed {
    logic                          valid;
    logic                          reg_write;
    logic                          is_load;
    logic [REG_ADDR_W-1:0]         rd;
    logic [NUM_SRC*REG_ADDR_W-1:0] rs;
    logic [NUM_SRC-1:0]            rs_used;
  } ex_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  is_load;
    logic [REG_ADDR_W-1:0] rd;
  } mem_t;

  // Load flag is dropped at WB: a WB result is always available.
  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
  } wb_t;

  ex_t          r_ex;
  mem_t         r_mem;
  wb_t          r_wb;
  logic [2:0]   r_cnt;

  ex_t          w_id;
  logic [2:0]   w_cnt_nxt;
  logic         w_ex_elig;
  logic         w_mem_elig;
  logic         w_wb_elig;
  logic         w_hazard;
  logic [NUM_SRC-1:0] w_id_hit;
  logic [NUM_SRC-1:0] w_mem_hit;
  logic [NUM_SRC-1:0] w_wb_hit;

  always_comb begin
    w_id         = '0;
    w_id.valid   = id_valid;
    w_id.reg_write = id_reg_write;
    w_id.is_load = id_is_load;
    w_id.rd      = id_rd;
    w_id.rs      = id_rs;
    w_id.rs_used = id_rs_used;
  end

  assign w_ex_elig  = r_ex.valid & r_ex.reg_write & (|r_ex.rd);
  assign w_mem_elig = r_mem.valid & r_mem.reg_write & (|r_mem.rd);
  assign w_wb_elig  = r_wb.valid & r_wb.reg_write & (|r_wb.rd);

  always_comb begin
    w_id_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_id_hit[i] = id_rs_used[i] &&
        (id_rs[i*REG_ADDR_W +: REG_ADDR_W] == r_ex.rd);
    end
  end

  assign w_hazard = id_valid & w_ex_elig & r_ex.is_load & (|w_id_hit);

  assign stall_out = !flush && ((r_cnt != 3'd0) || w_hazard);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (flush) begin
      w_cnt_nxt = 3'd0;
    end else if (r_cnt != 3'd0) begin
      w_cnt_nxt = r_cnt - 3'd1;
    end else if (w_hazard) begin
      w_cnt_nxt = STALL_RELOAD;
    end
  end

  always_comb begin
    w_mem_hit = '0;
    w_wb_hit  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_mem_hit[i] = w_mem_elig && !r_mem.is_load &&
        (r_mem.rd == r_ex.rs[i*REG_ADDR_W +: REG_ADDR_W]);
      w_wb_hit[i]  = w_wb_elig &&
        (r_wb.rd == r_ex.rs[i*REG_ADDR_W +: REG_ADDR_W]);
    end
  end

  // The younger producer in MEM shadows an older one in WB.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_ex.valid && r_ex.rs_used[i]) begin
        if (w_mem_hit[i]) begin
          fwd_sel[2*i +: 2] = 2'b01;
        end else if (w_wb_hit[i]) begin
          fwd_sel[2*i +: 2] = 2'b10;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
      r_cnt <= 3'd0;
    end else begin
      r_wb.valid     <= r_mem.valid;
      r_wb.reg_write <= r_mem.reg_write;
      r_wb.rd        <= r_mem.rd;
      r_mem.valid     <= r_ex.valid;
      r_mem.reg_write <= r_ex.reg_write;
      r_mem.is_load   <= r_ex.is_load;
      r_mem.rd        <= r_ex.rd;
      r_cnt <= w_cnt_nxt;
      if (stall_out || flush) begin
        r_ex <= '0;
      end else begin
        r_ex <= w_id;
      end
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] r_stat_fwd;
  logic [31:0] r_stat_stall;
  logic [31:0] w_fwd_n;
  logic [32:0] w_fwd_sum;

  always_comb begin
    w_fwd_n = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_fwd_n = w_fwd_n + 32'(fwd_sel[2*i +: 2] != 2'b00);
    end
  end

  assign w_fwd_sum = {1'b0, r_stat_fwd} + {1'b0, w_fwd_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_fwd   <= '0;
      r_stat_stall <= '0;
    end else begin
      r_stat_fwd <= w_fwd_sum[32] ? 32'hFFFF_FFFF : w_fwd_sum[31:0];
      if (stall_out && (r_stat_stall != 32'hFFFF_FFFF)) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
    end
  end

  assign stat_fwd_cnt   = r_stat_fwd;
  assign stat_stall_cnt = r_stat_stall;
`endif

endmodule
